// File: rtl/button_controller_if.sv
// Pin/event bundle for the button controller: raw pins and repeat mask in,
// sample tick, debounced levels and event pulses out.
interface button_controller_if #(
  parameter int N = 4
);
  logic [N-1:0] Pins;
  logic [N-1:0] Repeat_Mask;
  logic         Sample_Ena;
  logic [N-1:0] Buttons;
  logic [N-1:0] Pressed;
  logic [N-1:0] Released;
  logic [N-1:0] Repeat;

  modport master (
    output Pins, Repeat_Mask,
    input  Sample_Ena, Buttons, Pressed, Released, Repeat
  );

  modport slave (
    input  Pins, Repeat_Mask,
    output Sample_Ena, Buttons, Pressed, Released, Repeat
  );
endinterface

// File: rtl/button_controller.sv
// Multi-button front end: sample-tick prescaler, two-flop pin synchronisers,
// per-button tick-based debounce and a press/hold/auto-repeat event FSM.
module button_controller #(
  parameter int N            = 4,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE       = 16,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input logic                Clk,
  input logic                nReset,
  button_controller_if.slave bus
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW   = (STABLE > 1) ? $clog2(STABLE) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [PW-1:0] PS_LAST  = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(STABLE - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, HOLD, RPT} state_t;

  logic [PW-1:0] ps_cnt;
  logic          tick;
  logic [N-1:0]  sync_p0, sync_p1;
  logic [N-1:0]  level;
  logic [DW-1:0] db_cnt [N];
  logic [RW-1:0] rp_cnt [N];
  state_t        state  [N];
  logic [N-1:0]  pressed, released, rpt;
  logic [N-1:0]  differ, accept;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      ps_cnt <= '0;
      tick   <= 1'b0;
    end else if (ps_cnt == PS_LAST) begin
      ps_cnt <= '0;
      tick   <= 1'b1;
    end else begin
      ps_cnt <= ps_cnt + 1'b1;
      tick   <= 1'b0;
    end
  end

  // Stage p0/p1: two-flop synchroniser, idles at the released level
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= bus.Pins;
      sync_p1 <= sync_p0;
    end
  end

  always_comb begin
    differ = '0;
    accept = '0;
    for (int i = 0; i < N; i++) begin
      differ[i] = sync_p1[i] != level[i];
      accept[i] = tick && differ[i] && (db_cnt[i] == DB_LAST);
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      level    <= '1;
      pressed  <= '0;
      released <= '0;
      rpt      <= '0;
      for (int i = 0; i < N; i++) begin
        db_cnt[i] <= '0;
        rp_cnt[i] <= '0;
        state[i]  <= IDLE;
      end
    end else begin
      pressed  <= '0;
      released <= '0;
      rpt      <= '0;
      if (tick) begin
        for (int i = 0; i < N; i++) begin
          if (!differ[i]) begin
            db_cnt[i] <= '0;
          end else if (accept[i]) begin
            level[i]  <= sync_p1[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end

          // Release acceptance is tested first so it always beats a due repeat
          case (state[i])
            IDLE: begin
              if (accept[i] && !sync_p1[i]) begin
                pressed[i] <= 1'b1;
                rp_cnt[i]  <= '0;
                state[i]   <= HOLD;
              end
            end
            HOLD: begin
              if (accept[i] && sync_p1[i]) begin
                released[i] <= 1'b1;
                state[i]    <= IDLE;
              end else if (!bus.Repeat_Mask[i]) begin
                rp_cnt[i] <= '0;
              end else if (rp_cnt[i] == DLY_LAST) begin
                rpt[i]    <= 1'b1;
                rp_cnt[i] <= '0;
                state[i]  <= RPT;
              end else begin
                rp_cnt[i] <= rp_cnt[i] + 1'b1;
              end
            end
            RPT: begin
              if (accept[i] && sync_p1[i]) begin
                released[i] <= 1'b1;
                state[i]    <= IDLE;
              end else if (!bus.Repeat_Mask[i]) begin
                rp_cnt[i] <= '0;
                state[i]  <= HOLD;
              end else if (rp_cnt[i] == RPT_LAST) begin
                rpt[i]    <= 1'b1;
                rp_cnt[i] <= '0;
              end else begin
                rp_cnt[i] <= rp_cnt[i] + 1'b1;
              end
            end
            default: state[i] <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.Sample_Ena = tick;
  assign bus.Buttons    = level;
  assign bus.Pressed    = pressed;
  assign bus.Released   = released;
  assign bus.Repeat     = rpt;

endmodule
